// File: rtl/instr_prefetch_buf_if.sv
// Core fetch port, instruction memory port and performance counters of instr_prefetch_buf.
// slave: the prefetch buffer side; master: the core/memory environment side.
interface instr_prefetch_buf_if;
   logic        core_req_i;
   logic [31:0] core_addr_i;
   logic        core_gnt_o;
   logic        core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   modport slave (
      input  core_req_i, core_addr_i, mem_rvalid_i, mem_rdata_i,
      output core_gnt_o, core_rvalid_o, core_rdata_o, mem_req_o, mem_addr_o,
      output hit_cnt_o, miss_cnt_o
   );

   modport master (
      output core_req_i, core_addr_i, mem_rvalid_i, mem_rdata_i,
      input  core_gnt_o, core_rvalid_o, core_rdata_o, mem_req_o, mem_addr_o,
      input  hit_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetch buffer: a Depth-entry FIFO of {word address, data} fed by a
// fixed 1-cycle-latency memory port. A fetch that misses flushes the buffer and restarts
// prefetching at the missed address; the missed word is returned by bypass one cycle later.
// Optional hit/miss counters are built when PREFETCH_PERF_CNT_EN is defined.
module instr_prefetch_buf #(
   parameter int unsigned Depth = 4
) (
   input logic             clk_i,
   input logic             rst_ni,
   instr_prefetch_buf_if.slave bus
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
   localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(Depth);

   typedef logic [29:0] waddr_t;

   waddr_t          buf_addr_q [Depth];
   logic [31:0]     buf_data_q [Depth];
   logic [PtrW-1:0] head_q, tail_q;
   logic [CntW-1:0] count_q;
   logic            inflight_valid_q;
   waddr_t          inflight_addr_q;
   logic            pf_valid_q;
   waddr_t          pf_addr_q;
   logic            rvalid_q;
   logic [31:0]     rdata_q;

   waddr_t          req_addr;
   logic            hit_head, hit_bypass, hit, miss, prefetch, push, pop, mem_req;
   logic [CntW:0]   occupancy;
   waddr_t          mem_waddr;
   logic            unused_addr_lsb;

   assign unused_addr_lsb = ^bus.core_addr_i[1:0];

   // Hit/miss decode, prefetch throttling and memory request selection.
   always_comb begin
      req_addr   = bus.core_addr_i[31:2];
      hit_head   = bus.core_req_i && (count_q != '0) && (buf_addr_q[head_q] == req_addr);
      hit_bypass = bus.core_req_i && (count_q == '0) && bus.mem_rvalid_i && inflight_valid_q &&
                   (inflight_addr_q == req_addr);
      hit        = hit_head || hit_bypass;
      // Gated by reset so mem_req_o drops immediately while reset is held.
      miss       = bus.core_req_i && !hit && rst_ni;
      // Entries held after this cycle: the in-flight word lands either in the FIFO or is consumed.
      occupancy  = {1'b0, count_q} + (CntW + 1)'(inflight_valid_q) - (CntW + 1)'(hit);
      prefetch   = !miss && pf_valid_q && (occupancy < DepthOcc);
      mem_req    = miss || prefetch;
      mem_waddr  = miss ? req_addr : pf_addr_q;
      push       = inflight_valid_q && bus.mem_rvalid_i && !hit_bypass && !miss;
      pop        = hit_head;
   end

   assign bus.core_gnt_o    = hit;
   assign bus.core_rvalid_o = rvalid_q;
   assign bus.core_rdata_o  = rdata_q;
   assign bus.mem_req_o     = mem_req;
   assign bus.mem_addr_o    = mem_req ? {mem_waddr, 2'b00} : 32'h0;

   // FIFO pointers and occupancy; a miss flushes everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (miss) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop)  head_q <= head_q + PtrW'(1);
         if (push) tail_q <= tail_q + PtrW'(1);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
      end
   end

   // FIFO storage; contents are only meaningful below count_q, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_addr_q[tail_q] <= inflight_addr_q;
         buf_data_q[tail_q] <= bus.mem_rdata_i;
      end
   end

   // Outstanding memory request and next sequential prefetch address (wraps modulo 2^30 words).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_valid_q <= 1'b0;
         inflight_addr_q  <= '0;
         pf_valid_q       <= 1'b0;
         pf_addr_q        <= '0;
      end else begin
         inflight_valid_q <= mem_req;
         inflight_addr_q  <= mem_waddr;
         if (miss) begin
            pf_valid_q <= 1'b1;
            pf_addr_q  <= req_addr + 30'd1;
         end else if (prefetch) begin
            pf_addr_q  <= pf_addr_q + 30'd1;
         end
      end
   end

   // Core response: data valid the cycle after a grant, held otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= hit;
         if (hit) rdata_q <= hit_head ? buf_data_q[head_q] : bus.mem_rdata_i;
      end
   end

   overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(push && !pop && count_q == DepthCnt));

`ifdef PREFETCH_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        last_req_q;
   waddr_t      last_addr_q;
   logic        miss_first;

   // A miss is counted once: on a fresh request or when the requested address changes.
   assign miss_first = miss && (!last_req_q || (last_addr_q != req_addr));

   // Saturating hit/miss counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         last_req_q  <= 1'b0;
         last_addr_q <= '0;
      end else begin
         last_req_q  <= bus.core_req_i;
         last_addr_q <= req_addr;
         if (hit && hit_cnt_q != 32'hFFFF_FFFF)         hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (miss_first && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign bus.hit_cnt_o  = hit_cnt_q;
   assign bus.miss_cnt_o = miss_cnt_q;
`else
   assign bus.hit_cnt_o  = 32'h0;
   assign bus.miss_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Bench for instr_prefetch_buf: directed scenarios plus randomized fetch streams, checked
// cycle by cycle against a queue-based model of the buffer. Set PREFETCH_PERF_CNT_EN to match
// the RTL build for the counter expectations.
module tb_instr_prefetch_buf;
   localparam int Depth = 4;

   logic clk;
   logic rst_n;
   instr_prefetch_buf_if bus ();

   instr_prefetch_buf #(.Depth(Depth)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: word addresses held in the buffer, outstanding request, prefetch pointer.
   logic [29:0] q_buf [$];
   logic        inf_v, pf_v, exp_rv;
   logic [29:0] inf_a, pf_a;
   logic [31:0] exp_rd;
   logic [31:0] e_hit, e_miss;
   logic        m_last_req;
   logic [29:0] m_last_a;
   // Memory responder pipeline (fixed one-cycle latency).
   logic        mv_q;
   logic [31:0] ma_q;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ (a * 32'h9E37_79B1);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      q_buf.delete();
      inf_v = 1'b0; inf_a = '0; pf_v = 1'b0; pf_a = '0;
      exp_rv = 1'b0; exp_rd = '0;
      e_hit = '0; e_miss = '0; m_last_req = 1'b0; m_last_a = '0;
   endtask

   // Called at a negedge: drive one cycle, check, advance the model, return at next negedge.
   task automatic step(input logic req, input logic [31:0] addr, output logic g);
      logic [29:0] a;
      logic        hq, bp, hit, miss, pf, emr;
      logic [31:0] ema, mrd;
      int          occ;
      bus.core_req_i  = req;
      bus.core_addr_i = addr;
      mrd             = mv_q ? mem_word(ma_q) : $urandom;
      bus.mem_rvalid_i = mv_q;
      bus.mem_rdata_i  = mrd;
      #1;
      a    = addr[31:2];
      hq   = req && (q_buf.size() > 0) && (q_buf[0] == a);
      bp   = req && (q_buf.size() == 0) && mv_q && inf_v && (inf_a == a);
      hit  = hq || bp;
      miss = req && !hit;
      occ  = q_buf.size() + int'(inf_v) - int'(hit);
      pf   = !miss && pf_v && (occ < Depth);
      emr  = miss || pf;
      ema  = miss ? {a, 2'b00} : {pf_a, 2'b00};

      check_eq("gnt", bus.core_gnt_o, hit);
      check_eq("rvalid", bus.core_rvalid_o, exp_rv);
      if (exp_rv) check_eq("rdata", bus.core_rdata_o, exp_rd);
      check_eq("mem_req", bus.mem_req_o, emr);
      if (emr) check_eq("mem_addr", bus.mem_addr_o, ema);
      check_eq("hit_cnt", bus.hit_cnt_o, e_hit);
      check_eq("miss_cnt", bus.miss_cnt_o, e_miss);
      g = bus.core_gnt_o;

`ifdef PREFETCH_PERF_CNT_EN
      if (hit && e_hit != 32'hFFFF_FFFF) e_hit++;
      if (miss && (!m_last_req || m_last_a != a) && e_miss != 32'hFFFF_FFFF) e_miss++;
`endif
      m_last_req = req;
      m_last_a   = a;
      exp_rv = hit;
      if (hit) exp_rd = mem_word({a, 2'b00});
      if (miss) q_buf.delete();
      else begin
         if (hq) void'(q_buf.pop_front());
         if (inf_v && mv_q && !bp) q_buf.push_back(inf_a);
      end
      inf_v = emr;
      inf_a = ema[31:2];
      if (miss) begin pf_v = 1'b1; pf_a = a + 30'd1; end
      else if (pf) pf_a = pf_a + 30'd1;
      mv_q = bus.mem_req_o;
      ma_q = bus.mem_addr_o;
      @(negedge clk);
   endtask

   // Fetch n sequential words; the core advances on the DUT's grant.
   task automatic fetch_seq(input logic [31:0] start, input int n,
                            output int first_g, output int cycles);
      logic [31:0] a;
      logic        g;
      int          got;
      a = start; got = 0; cycles = 0; first_g = -1;
      while (got < n && cycles < 4 * n + 10) begin
         step(1'b1, a, g);
         if (g) begin
            if (first_g < 0) first_g = cycles;
            got++;
            a += 32'd4;
         end
         cycles++;
      end
      check_eq("fetch_count", got, n);
   endtask

   // Called at a negedge; returns at the negedge after release with a stray response queued.
   task automatic do_reset();
      rst_n = 1'b0;
      bus.core_req_i   = 1'b1;
      bus.core_addr_i  = 32'h40;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = $urandom;
      #1;
      check_eq("rst_gnt", bus.core_gnt_o, 0);
      check_eq("rst_rvalid", bus.core_rvalid_o, 0);
      check_eq("rst_rdata", bus.core_rdata_o, 0);
      check_eq("rst_mem_req", bus.mem_req_o, 0);
      check_eq("rst_mem_addr", bus.mem_addr_o, 0);
      check_eq("rst_hit_cnt", bus.hit_cnt_o, 0);
      check_eq("rst_miss_cnt", bus.miss_cnt_o, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.core_req_i = 1'b0;
      mv_q = 1'b1;
      ma_q = 32'h40;
   endtask

   logic [31:0] cur;
   logic        g, rq;
   int          fg, cyc, r;

   initial begin
      rst_n = 1'b1;
      bus.core_req_i = 1'b0; bus.core_addr_i = '0;
      bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      mv_q = 1'b0; ma_q = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Idle after reset: stray response ignored, no memory traffic.
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, g);
      check_eq("idle_mem_req", bus.mem_req_o, 0);

      // First fetch from 0x0: miss, bypass grant one cycle later, then 16 sequential words.
      fetch_seq(32'h0, 16, fg, cyc);
      check_eq("first_gnt_cycle", fg, 1);
      check_eq("seq_cycles", cyc, 17);
      step(1'b1, 32'h100, g);
`ifdef PREFETCH_PERF_CNT_EN
      check_eq("perf_hits", bus.hit_cnt_o, 16);
      check_eq("perf_misses", bus.miss_cnt_o, 2);
`else
      check_eq("perf_hits", bus.hit_cnt_o, 0);
      check_eq("perf_misses", bus.miss_cnt_o, 0);
`endif
      fetch_seq(32'h100, 1, fg, cyc);

      // Jump after 0x8: stale sequential data discarded.
      fetch_seq(32'h0, 3, fg, cyc);
      fetch_seq(32'h100, 1, fg, cyc);
      check_eq("jump_cycles", cyc, 2);
      step(1'b0, 32'h0, g);

      // Stall at 0x20: buffer fills, then four back-to-back hits.
      fetch_seq(32'h0, 8, fg, cyc);
      for (int i = 0; i < 10; i++) step(1'b0, 32'h20, g);
      check_eq("stall_mem_req", bus.mem_req_o, 0);
      fetch_seq(32'h20, 4, fg, cyc);
      check_eq("resume_b2b_cycles", cyc, 4);

      // Address wrap.
      fetch_seq(32'hFFFF_FFF8, 4, fg, cyc);
      check_eq("wrap_cycles", cyc, 5);

      // Randomized fetch stream.
      cur = 32'h1000;
      for (int i = 0; i < 1500; i++) begin
         rq = ($urandom_range(0, 99) < 85);
         step(rq, cur, g);
         r = $urandom_range(0, 99);
         if (g) begin
            if (r < 80)      cur = cur + 32'd4;
            else if (r < 88) cur = cur + 32'd4 * $urandom_range(0, 8) - 32'd16;
            else if (r < 94) cur = {$urandom, 2'b00};
            else             cur = 32'hFFFF_FFE0 + 32'd4 * $urandom_range(0, 7);
         end else if (rq && r < 3) begin
            cur = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
         end
      end

      // Reset in the middle of active fetching, then re-fetch the stray response's address.
      do_reset();
      for (int i = 0; i < 2; i++) step(1'b0, 32'h40, g);
      fetch_seq(32'h40, 2, fg, cyc);
      check_eq("post_rst_first_gnt", fg, 1);
      step(1'b0, 32'h0, g);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/instr_prefetch_buf.md
INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 Parameter: Depth, default 4, number of buffered instruction words (power of two, 2..16).
REQ-002 clk_i  input  1  system clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 core_req_i  input  1  core instruction fetch request.
REQ-005 core_addr_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 core_gnt_o  output  1  request accepted this cycle.
REQ-007 core_rvalid_o  output  1  fetch data valid, one cycle after grant.
REQ-008 core_rdata_o  output  32  fetched instruction word.
REQ-009 mem_req_o  output  1  read request to instruction memory port (fixed 1-cycle latency, always accepts).
REQ-010 mem_addr_o  output  32  word-aligned memory read address.
REQ-011 mem_rvalid_i  input  1  memory read data valid.
REQ-012 mem_rdata_i  input  32  memory read data.
REQ-013 hit_cnt_o  output  32  buffer hit count (see Configuration).
REQ-014 miss_cnt_o  output  32  buffer miss count (see Configuration).

Function
REQ-015 Buffer SHALL be a FIFO of Depth {addr[31:2], data} entries with head pointer, tail pointer, count (0..Depth).
REQ-016 SHALL hold registers inflight_q (valid, addr[31:2]) for the request issued last cycle, and pf_valid_q/pf_addr_q for the next sequential prefetch address.
REQ-017 Hit SHALL be: core_req_i and (count>0 and head addr == core_addr_i[31:2]) or (count==0 and mem_rvalid_i and inflight_q valid and inflight addr == core_addr_i[31:2]).
REQ-018 On hit: core_gnt_o=1 same cycle; next cycle core_rvalid_o=1 with matching data; head entry popped (or bypassed data consumed without write).
REQ-019 Miss (core_req_i and not hit): core_gnt_o=0; buffer flushed (count:=0); data arriving this cycle discarded; mem_req_o=1 with mem_addr_o={core_addr_i[31:2],2'b00}; pf_addr_q := core_addr_i[31:2]+1; pf_valid_q := 1.
REQ-020 Miss latency: request at cycle N, granted by bypass at N+1, core_rvalid_o at N+2; hit latency gnt at N, rvalid at N+1.
REQ-021 Prefetch: when no miss and pf_valid_q and count + inflight_q.valid - pop < Depth, mem_req_o=1, mem_addr_o={pf_addr_q,2'b00}, pf_addr_q increments by 1 word.
REQ-022 Address increment SHALL wrap modulo 2^30 words (0xFFFFFFFC -> 0x00000000).
REQ-023 mem_rvalid_i with valid, non-flushed inflight_q and not bypass-consumed SHALL push {inflight addr, mem_rdata_i} at tail.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; overflow impossible by REQ-021 and SHALL be asserted in simulation.
REQ-025 core_req_i low: no grant, buffer and prefetch continue filling.
REQ-026 core_rvalid_o SHALL be 0 in any cycle not following a grant; core_rdata_o holds last value otherwise.

Reset
REQ-027 On rst_ni low, immediately: count, pointers 0; inflight_q, pf_valid_q invalid; core_gnt_o, core_rvalid_o, mem_req_o 0; core_rdata_o, mem_addr_o 0; counters 0.
REQ-028 After reset no memory request SHALL issue until the first core request (miss).
REQ-029 Reset mid-fetch SHALL discard all in-flight and buffered data; a mem_rvalid_i in the first post-reset cycle SHALL be ignored.

Configuration
REQ-030 Macro PREFETCH_PERF_CNT_EN defined: hit_cnt_o increments per hit, miss_cnt_o per miss cycle only on the first cycle of a miss (core_req_i rising or address change), both saturating at 0xFFFFFFFF.
REQ-031 Macro undefined: counter logic absent; hit_cnt_o and miss_cnt_o tied to 0.

Verification
REQ-032 Reset, core_req_i=1 addr 0x0 -> mem_req_o at cycle 0 addr 0x0, gnt cycle 1, rvalid cycle 2 with mem[0x0]; prefetches 0x4,0x8,0xC,0x10 follow.
REQ-033 Sequential fetch 0x0..0x3C after warm-up -> one grant per cycle, rdata matches memory, no miss, count never exceeds 4.
REQ-034 Fetch 0x8 then jump to 0x100 -> miss, buffer flushed, stale 0xC data discarded, rvalid 2 cycles later with mem[0x100].
REQ-035 Stall core_req_i low 10 cycles at 0x20 -> buffer fills to Depth, mem_req_o low, resume gives back-to-back hits 0x20,0x24,0x28,0x2C.
REQ-036 Fetch at 0xFFFFFFF8 -> prefetch addresses 0xFFFFFFFC then 0x00000000.
REQ-037 With PREFETCH_PERF_CNT_EN, 16 sequential fetches from 0x0 plus one jump -> miss_cnt_o=2, hit_cnt_o=16; without macro both 0.
